// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the nibble-sliced down counter family.
// Holds the nibble width, the two nibble boundary values used by the
// decrement and zero-detect logic, and the nibble data type.
package counter_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [NIBBLE_W-1:0] NIBBLE_ZERO = 4'h0;
  localparam logic [NIBBLE_W-1:0] NIBBLE_MAX  = 4'hF;

  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/down_nibble.sv
// down_nibble
// One 4-bit down-counting stage with the 74163 pinout. The terminal count
// output flags zero instead of all-ones so stages cascade as a borrow chain.
// Ports:
//   CP  - clock, rising edge
//   MR  - asynchronous active-high reset, clears Q
//   CEP - count enable parallel
//   CET - count enable trickle, also gates TC
//   _PE - active-low synchronous parallel load, overrides counting
//   D   - parallel load data
//   Q   - current nibble value
//   TC  - CET & (Q == 0), borrow out to the next stage
module down_nibble
  import counter_pkg::*;
(
  input  logic    CP,
  input  logic    MR,
  input  logic    CEP,
  input  logic    CET,
  input  logic    _PE,
  input  nibble_t D,
  output nibble_t Q,
  output logic    TC
);

  nibble_t count_q;
  nibble_t count_d;

  // Next nibble value: load beats counting, counting beats holding.
  // Written with the conditional operator so an X on an enable shows up
  // as X on the counter rather than silently picking one branch.
  // Adding all-ones is a decrement modulo 16, so 0 wraps to F.
  always_comb begin
    count_d = !_PE ? D
            : ((CEP & CET) ? nibble_t'(count_q + NIBBLE_MAX) : count_q);
  end

  // Counter register; MR clears it at once, independent of the clock.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      count_q <= NIBBLE_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign Q  = count_q;
  assign TC = CET & (count_q == NIBBLE_ZERO);

endmodule

// File: rtl/down_counter_reg.sv
// down_counter_reg
// Loadable down counter built from cascaded down_nibble stages, with a
// reload register for periodic (auto-reload) operation and a registered
// zero pulse. Pin-compatible in naming and enable semantics with the
// 74163-style up counter register.
// Ports:
//   CP  - clock, rising edge
//   MR  - asynchronous active-high reset, clears Q, RL and ZP
//   CEP - count enable parallel
//   CET - count enable trickle, also gates TC
//   _PE - active-low synchronous load of Q from D
//   _LR - active-low synchronous load of RL from D
//   ARL - auto-reload enable: counting at zero reloads Q from RL
//   D   - load data for Q and/or RL
//   Q   - counter value
//   RL  - reload register value
//   TC  - terminal count, CET & (Q == 0), combinational
//   ZP  - one-cycle pulse after a counting step lands on zero
module down_counter_reg
  import counter_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                         CP,
  input  logic                         MR,
  input  logic                         CEP,
  input  logic                         CET,
  input  logic                         _PE,
  input  logic                         _LR,
  input  logic                         ARL,
  input  logic [NIBBLE_W*NIBBLES-1:0]  D,
  output logic [NIBBLE_W*NIBBLES-1:0]  Q,
  output logic [NIBBLE_W*NIBBLES-1:0]  RL,
  output logic                         TC,
  output logic                         ZP
);

  localparam int W = NIBBLE_W * NIBBLES;

  logic [W-1:0]     rl_q;
  logic [W-1:0]     rl_d;
  logic             zp_q;
  logic             zp_d;
  logic             reloadNow;
  logic             nibbleLoadN;
  logic [W-1:0]     nibbleD;
  logic [NIBBLES:0] cetChain;

  // Auto-reload happens when a counting edge finds the counter at zero.
  // It is turned into an ordinary parallel load of the nibbles from RL, so
  // the nibble stays a plain 74163-style part. An explicit _PE load keeps
  // priority by selecting D over RL.
  assign reloadNow   = CEP & CET & (Q == '0) & ARL;
  assign nibbleLoadN = _PE & ~reloadNow;
  assign nibbleD     = !_PE ? D : rl_q;

  // Borrow chain: each stage may only count when all lower stages are zero.
  assign cetChain[0] = CET;

  for (genvar k = 0; k < NIBBLES; k++) begin : gNibble
    down_nibble uNibble (
      .CP  (CP),
      .MR  (MR),
      .CEP (CEP),
      .CET (cetChain[k]),
      ._PE (nibbleLoadN),
      .D   (nibbleD[k*NIBBLE_W +: NIBBLE_W]),
      .Q   (Q[k*NIBBLE_W +: NIBBLE_W]),
      .TC  (cetChain[k+1])
    );
  end

  // Reload register takes D on _LR low; otherwise it holds. The reload
  // path above reads rl_q, so a same-edge reload sees the old value.
  // A true decrement from 1 is the only event that raises the zero pulse;
  // loads and reloads of zero never do (Q == 1 rules out a reload).
  always_comb begin
    rl_d = !_LR ? D : rl_q;
    zp_d = _PE & CEP & CET & (Q == W'(1));
  end

  // Reload and zero-pulse registers, cleared asynchronously with the count.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      rl_q <= '0;
      zp_q <= 1'b0;
    end else begin
      rl_q <= rl_d;
      zp_q <= zp_d;
    end
  end

  assign RL = rl_q;
  assign ZP = zp_q;
  assign TC = cetChain[NIBBLES];

endmodule

// File: tb/tb_down_counter_reg.sv
// tb_down_counter_reg
// Self-checking bench for down_counter_reg (two nibbles, 8 bits). A plain
// arithmetic model of the counter rules predicts Q, RL, ZP and TC; directed
// scenarios are followed by a randomized run.
module tb_down_counter_reg;

  logic       CP;
  logic       MR;
  logic       CEP;
  logic       CET;
  logic       _PE;
  logic       _LR;
  logic       ARL;
  logic [7:0] D;
  logic [7:0] Q;
  logic [7:0] RL;
  logic       TC;
  logic       ZP;

  int total = 0;
  int bad   = 0;

  int modelQ  = 0;
  int modelRl = 0;
  int modelZp = 0;

  down_counter_reg #(.NIBBLES(2)) dut (
    .CP  (CP),
    .MR  (MR),
    .CEP (CEP),
    .CET (CET),
    ._PE (_PE),
    ._LR (_LR),
    .ARL (ARL),
    .D   (D),
    .Q   (Q),
    .RL  (RL),
    .TC  (TC),
    .ZP  (ZP)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  // Drives one set of inputs, lets one rising edge happen and advances the
  // model by the counter rules. Returns #1 after the edge.
  task automatic applyStimulus(input logic pe, input logic lr, input logic cep,
                               input logic cet, input logic arl,
                               input logic [7:0] d);
    int nextQ;
    int nextRl;
    int nextZp;
    _PE = pe;
    _LR = lr;
    CEP = cep;
    CET = cet;
    ARL = arl;
    D   = d;
    if (MR) begin
      nextQ  = 0;
      nextRl = 0;
      nextZp = 0;
    end else begin
      if (!pe)                                   nextQ = d;
      else if (cep && cet && arl && modelQ == 0) nextQ = modelRl;
      else if (cep && cet)                       nextQ = (modelQ + 255) % 256;
      else                                       nextQ = modelQ;
      nextRl = !lr ? int'(d) : modelRl;
      nextZp = (pe && cep && cet && modelQ == 1) ? 1 : 0;
    end
    @(posedge CP);
    #1;
    modelQ  = nextQ;
    modelRl = nextRl;
    modelZp = nextZp;
  endtask

  // Compares all four outputs against the model.
  task automatic checkOutput(input string tag);
    logic [7:0] expQ;
    logic [7:0] expRl;
    logic       expZp;
    logic       expTc;
    expQ  = 8'(modelQ);
    expRl = 8'(modelRl);
    expZp = (modelZp != 0);
    expTc = CET & (modelQ == 0);
    total++;
    assert (Q === expQ) else begin
      bad++;
      $error("[TB] FAIL %s Q actual=%h expected=%h", tag, Q, expQ);
    end
    total++;
    assert (RL === expRl) else begin
      bad++;
      $error("[TB] FAIL %s RL actual=%h expected=%h", tag, RL, expRl);
    end
    total++;
    assert (ZP === expZp) else begin
      bad++;
      $error("[TB] FAIL %s ZP actual=%b expected=%b", tag, ZP, expZp);
    end
    total++;
    assert (TC === expTc) else begin
      bad++;
      $error("[TB] FAIL %s TC actual=%b expected=%b", tag, TC, expTc);
    end
  endtask

  // Asserts MR between edges, checks the immediate clear and TC = CET,
  // clocks a few ignored edges, then releases MR away from an edge.
  task automatic pulseReset(input string tag);
    #3;
    MR = 1'b1;
    #1;
    modelQ  = 0;
    modelRl = 0;
    modelZp = 0;
    CET = 1'b0;
    #1;
    checkOutput({tag, "_cet0"});
    CET = 1'b1;
    #1;
    checkOutput({tag, "_cet1"});
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
      checkOutput({tag, "_held"});
    end
    MR = 1'b0;
  endtask

  initial begin
    MR  = 1'b1;
    CEP = 1'b0;
    CET = 1'b0;
    _PE = 1'b1;
    _LR = 1'b1;
    ARL = 1'b0;
    D   = 8'h00;
    #2;
    checkOutput("reset_init");
    @(posedge CP);
    #1;
    MR = 1'b0;

    // Load 3 and count down through zero into the wrap.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    checkOutput("load3");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("count_wrap");
    end

    // Borrow from the upper nibble, then CET low freezes a zero count.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
    checkOutput("load10");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("borrow_0F");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("borrow_0E");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("load0");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("cet_low_hold");

    // Auto-reload as a divide-by-3 period.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02);
    checkOutput("load_rl2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    checkOutput("load1");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      checkOutput("autoreload");
    end

    // Reload and RL load on one edge, then both loads together.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    checkOutput("to_zero");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07);
    checkOutput("reload_and_lr");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44);
    checkOutput("pe_and_lr");

    // Load priority over idle enables and over auto-reload.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
    checkOutput("pe_idle");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("load0_again");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    checkOutput("pe_over_reload");

    // Reset with ZP high and RL nonzero.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("pre_reset_zp");
    pulseReset("reset_zp");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("resume");

    // Reset with a nonzero count.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
    checkOutput("pre_reset_5a");
    pulseReset("reset_5a");

    // Randomized run; loads are kept rare so long count runs happen.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(7) != 0), ($urandom_range(9) != 0),
                    ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                    1'($urandom_range(1)),
                    ($urandom_range(1) != 0) ? 8'($urandom_range(3))
                                             : 8'($urandom));
      checkOutput("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
